// File: rtl/grf_wb_arbiter_if.sv
// Signal bundle between the writeback arbiter and its environment.
// The slave side is the arbiter; the master side issues requests and observes the GRF port.
interface grf_wb_arbiter_if;
    logic        w_we;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic [31:0] w_pc;
    logic        l_valid;
    logic [4:0]  l_a3;
    logic [31:0] l_wd;
    logic [31:0] l_pc;
    logic        l_ready;
    logic        l_alloc;
    logic [4:0]  l_alloc_a3;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_wpc;
    logic [31:0] busy;
    logic [3:0]  fifo_cnt;
    logic        drain_req;

    modport slave (
        input  w_we, w_a3, w_wd, w_pc,
        input  l_valid, l_a3, l_wd, l_pc,
        input  l_alloc, l_alloc_a3,
        output l_ready,
        output grf_we, grf_a3, grf_wd, grf_wpc,
        output busy, fifo_cnt, drain_req
    );

    modport master (
        output w_we, w_a3, w_wd, w_pc,
        output l_valid, l_a3, l_wd, l_pc,
        output l_alloc, l_alloc_a3,
        input  l_ready,
        input  grf_we, grf_a3, grf_wd, grf_wpc,
        input  busy, fifo_cnt, drain_req
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between the W stage (priority) and a small FIFO of
// late writebacks from multi-cycle units, and keeps a reservation scoreboard.
module grf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    grf_wb_arbiter_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [3:0]    FULL_CNT = 4'(DEPTH);

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [3:0]    cnt_reg;
    logic [31:0]   busy_reg;
    logic [31:0]   busy_next;
    entry_t        head_entry;
    logic          w_valid;
    logic          full;
    logic          ready;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Reset gates the combinational paths so outputs drop without waiting for a clock edge.
    assign head_entry = mem[head_reg];
    assign full       = (cnt_reg == FULL_CNT);
    assign ready      = reset && !full;
    assign w_valid    = reset && bus.w_we && (bus.w_a3 != 5'd0);
    assign pop        = reset && !w_valid && (cnt_reg != 4'd0);
    assign push       = ready && bus.l_valid && (bus.l_a3 != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= '0;
        end else begin
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (push && !pop) begin
                cnt_reg <= cnt_reg + 4'd1;
            end else if (pop && !push) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            busy_reg <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= {bus.l_a3, bus.l_wd, bus.l_pc};
        end
    end

    // A reservation landing on the same edge as the pop that clears it keeps the bit set.
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_bit
            logic set_bit;
            logic clr_bit;
            assign set_bit       = bus.l_alloc && (bus.l_alloc_a3 == 5'(gi));
            assign clr_bit       = pop && (head_entry.a3 == 5'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    end

    always_comb begin
        bus.grf_we  = 1'b0;
        bus.grf_a3  = '0;
        bus.grf_wd  = '0;
        bus.grf_wpc = '0;
        if (w_valid) begin
            bus.grf_we  = 1'b1;
            bus.grf_a3  = bus.w_a3;
            bus.grf_wd  = bus.w_wd;
            bus.grf_wpc = bus.w_pc;
        end else if (pop) begin
            bus.grf_we  = 1'b1;
            bus.grf_a3  = head_entry.a3;
            bus.grf_wd  = head_entry.wd;
            bus.grf_wpc = head_entry.pc;
        end
    end

    assign bus.l_ready   = ready;
    assign bus.busy      = busy_reg;
    assign bus.fifo_cnt  = cnt_reg;
    assign bus.drain_req = full;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench: a queue-based model of the writeback arbiter checked every cycle,
// with directed scenarios pinned by literal expectations and a randomized phase.
module tb_grf_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    grf_wb_arbiter_if bus();

    grf_wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_busy;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          last_acc;
    logic        pend_v;
    logic [4:0]  pend_a;
    logic [31:0] pend_d;
    logic [31:0] saved_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow directly from the priority rule: W first, else FIFO head, else idle.
    task automatic check_model();
        bit          wv;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        wv   = bus.w_we && (bus.w_a3 != 5'd0);
        e_we = 1'b0;
        e_a3 = '0;
        e_wd = '0;
        e_pc = '0;
        if (wv) begin
            e_we = 1'b1; e_a3 = bus.w_a3; e_wd = bus.w_wd; e_pc = bus.w_pc;
        end else if (q.size() > 0) begin
            e_we = 1'b1; e_a3 = q[0].a3; e_wd = q[0].wd; e_pc = q[0].pc;
        end
        chk("l_ready",   32'(bus.l_ready),   32'(q.size() < DEPTH));
        chk("grf_we",    32'(bus.grf_we),    32'(e_we));
        chk("grf_a3",    32'(bus.grf_a3),    32'(e_a3));
        chk("grf_wd",    bus.grf_wd,         e_wd);
        chk("grf_wpc",   bus.grf_wpc,        e_pc);
        chk("busy",      bus.busy,           m_busy);
        chk("fifo_cnt",  32'(bus.fifo_cnt),  32'(q.size()));
        chk("drain_req", 32'(bus.drain_req), 32'(q.size() == DEPTH));
    endtask

    task automatic apply(input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic al, input logic [4:0] aa);
        bus.w_we       = ww;
        bus.w_a3       = wa;
        bus.w_wd       = wd;
        bus.w_pc       = wd ^ 32'h4000_0000;
        bus.l_valid    = lv;
        bus.l_a3       = la;
        bus.l_wd       = ld;
        bus.l_pc       = ld + 32'h100;
        bus.l_alloc    = al;
        bus.l_alloc_a3 = aa;
        #1;
        check_model();
    endtask

    task automatic tick();
        bit   wv;
        bit   acc;
        ent_t e;
        wv  = bus.w_we && (bus.w_a3 != 5'd0);
        acc = bus.l_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (!wv && q.size() > 0) begin
            e = q.pop_front();
            m_busy[e.a3] = 1'b0;
            $display("pop  a3=%0d wd=0x%08h pc=0x%08h", e.a3, e.wd, e.pc);
        end
        if (acc && bus.l_a3 != 5'd0) begin
            q.push_back('{a3: bus.l_a3, wd: bus.l_wd, pc: bus.l_pc});
        end
        if (bus.l_alloc && bus.l_alloc_a3 != 5'd0) begin
            m_busy[bus.l_alloc_a3] = 1'b1;
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic quiesce();
        int n = 0;
        while ((pend_v || q.size() > 0) && n < 20) begin
            apply(1'b0, 5'd0, 32'd0, pend_v, pend_a, pend_d, 1'b0, 5'd0);
            tick();
            if (last_acc) pend_v = 1'b0;
            n++;
        end
        chk("quiesce_cnt", 32'(bus.fifo_cnt), 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        m_busy = '0;
        last_acc = 1'b0;
        pend_v = 1'b0;
        pend_a = '0;
        pend_d = '0;
        bus.w_we = 1'b0; bus.w_a3 = '0; bus.w_wd = '0; bus.w_pc = '0;
        bus.l_valid = 1'b0; bus.l_a3 = '0; bus.l_wd = '0; bus.l_pc = '0;
        bus.l_alloc = 1'b0; bus.l_alloc_a3 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("rst_l_ready",  32'(bus.l_ready),  32'd0);
        chk("rst_grf_we",   32'(bus.grf_we),   32'd0);
        chk("rst_busy",     bus.busy,          32'd0);
        chk("rst_drain",    32'(bus.drain_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single late write reaches the GRF one cycle after acceptance.
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
        chk("d033_we_accept_cycle", 32'(bus.grf_we), 32'd0);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d033_we", 32'(bus.grf_we), 32'd1);
        chk("d033_a3", 32'(bus.grf_a3), 32'd5);
        chk("d033_wd", bus.grf_wd, 32'h1234);
        chk("d033_cnt1", 32'(bus.fifo_cnt), 32'd1);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d033_cnt0", 32'(bus.fifo_cnt), 32'd0);
        tick();

        // W owns the port every cycle; FIFO fills, then drains in order once W goes idle.
        apply(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA, 1'b0, 5'd0); tick();
        apply(1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'hB, 1'b0, 5'd0); tick();
        apply(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0);
        chk("d034_ready", 32'(bus.l_ready), 32'd0);
        chk("d034_drain", 32'(bus.drain_req), 32'd1);
        chk("d034_w_a3", 32'(bus.grf_a3), 32'd3);
        tick();
        apply(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0);
        chk("d034_cnt_full", 32'(bus.fifo_cnt), 32'd2);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0);
        chk("d034_first_a3", 32'(bus.grf_a3), 32'd10);
        chk("d034_first_wd", bus.grf_wd, 32'hA);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0);
        chk("d034_second_a3", 32'(bus.grf_a3), 32'd11);
        chk("d034_ready_again", 32'(bus.l_ready), 32'd1);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d034_third_a3", 32'(bus.grf_a3), 32'd12);
        chk("d034_third_wd", bus.grf_wd, 32'hC);
        tick();

        // Reservation re-issued on the edge its previous write pops keeps the bit set.
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7); tick();
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        chk("d035_busy7_set", 32'(bus.busy[7]), 32'd1);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        chk("d035_pop_a3", 32'(bus.grf_a3), 32'd7);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0);
        chk("d035_busy7_kept", 32'(bus.busy[7]), 32'd1);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d035_busy7_clear", 32'(bus.busy[7]), 32'd0);
        tick();

        // Register 0 reservations and writebacks are no-ops.
        saved_busy = m_busy;
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0);
        chk("d036_ready", 32'(bus.l_ready), 32'd1);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d036_we", 32'(bus.grf_we), 32'd0);
        chk("d036_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("d036_busy", bus.busy, saved_busy);
        tick();

        // Steady push/pop at occupancy 1 walks both pointers around the ring.
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'hA000, 1'b0, 5'd0); tick();
        for (int i = 1; i <= 10; i++) begin
            apply(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b0, 5'd0);
            chk("d038_cnt", 32'(bus.fifo_cnt), 32'd1);
            chk("d038_wd", bus.grf_wd, 32'hA000 + 32'(i - 1));
            tick();
        end
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d038_last_wd", bus.grf_wd, 32'hA00A);
        tick();

        // Randomized traffic; an unaccepted late request holds its payload.
        for (int i = 0; i < 400; i++) begin
            if (!(pend_v && !last_acc)) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                pend_d = $urandom;
            end
            apply($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                  pend_v, pend_a, pend_d, $urandom_range(0, 3) == 0, 5'($urandom));
            tick();
        end
        if (last_acc) pend_v = 1'b0;
        quiesce();

        // Mid-cycle reset with a full FIFO and an active W request.
        apply(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'hE0, 1'b0, 5'd0); tick();
        apply(1'b1, 5'd3, 32'h33, 1'b1, 5'd21, 32'hE1, 1'b1, 5'd20); tick();
        apply(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d037_cnt_pre", 32'(bus.fifo_cnt), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("d037_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("d037_ready", 32'(bus.l_ready), 32'd0);
        chk("d037_we", 32'(bus.grf_we), 32'd0);
        chk("d037_drain", 32'(bus.drain_req), 32'd0);
        chk("d037_busy", bus.busy, 32'd0);
        q.delete();
        m_busy = '0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("d037_we_in_reset", 32'(bus.grf_we), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        chk("d037_no_stale", 32'(bus.grf_we), 32'd0);
        chk("d032_ready", 32'(bus.l_ready), 32'd1);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("d032_a3", 32'(bus.grf_a3), 32'd6);
        chk("d032_wd", bus.grf_wd, 32'h66);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
